peri_timer_slave: RTL and testbench

// - Responder on the peri bus (req/gnt/rvalid); sits behind the peripherals address decoder.
// - Provides a 64-bit prescaled free-running mtime counter and a 64-bit mtimecmp compare register.
// - Drives irq_timer_o into the core's timer interrupt line.
// - Base address is decoded upstream. The block uses peri_addr[11:0] only.

---
 rtl/peri_timer_slave.sv | 156 +++++++++++++++
 tb/tb_peri_timer_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/peri_timer_slave.sv
// Peri-bus timer responder: 64-bit prescaled mtime, 64-bit mtimecmp and a level
// timer interrupt. Single-cycle read/write response, never stalls.
module peri_timer_slave #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        peri_req,
    input  logic [31:0] peri_addr,
    input  logic        peri_write,
    input  logic [3:0]  peri_be,
    input  logic [31:0] peri_wdata,
    output logic        peri_gnt,
    output logic        peri_rvalid,
    output logic [31:0] peri_rdata,
    output logic        irq_timer_o
);

    localparam logic [2:0] IdxCtrl     = 3'd0;
    localparam logic [2:0] IdxPrescale = 3'd1;
    localparam logic [2:0] IdxMtimeLo  = 3'd2;
    localparam logic [2:0] IdxMtimeHi  = 3'd3;
    localparam logic [2:0] IdxCmpLo    = 3'd4;
    localparam logic [2:0] IdxCmpHi    = 3'd5;
    localparam logic [2:0] IdxStatus   = 3'd6;

    logic [1:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [31:0]           shadow_hi_q, shadow_hi_d;
    logic                  rvalid_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  irq_q, irq_d;

    logic [2:0]  idx;
    logic        hit;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic        status;
    logic [31:0] prescale_ext;
    logic [31:0] ctrl_wr;
    logic [31:0] prescale_wr;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    assign peri_gnt     = peri_req;
    assign peri_rvalid  = rvalid_q;
    assign peri_rdata   = rdata_q;
    assign irq_timer_o  = irq_q;

    assign idx          = peri_addr[4:2];
    assign hit          = (peri_addr[1:0] == 2'b00) && (peri_addr[11:5] == 7'd0) && (idx != 3'd7);
    // be == 0 is a true no-op: it neither writes nor clears the prescaler
    assign wr_en        = peri_req && peri_write && hit && (peri_be != 4'b0000);
    assign rd_en        = peri_req && !peri_write && hit;
    assign tick         = ctrl_q[0] && (pcnt_q == prescale_q);
    assign status       = (mtime_q >= mtimecmp_q);
    assign prescale_ext = 32'(prescale_q);
    assign ctrl_wr      = merge_bytes({30'd0, ctrl_q}, peri_wdata, peri_be);
    assign prescale_wr  = merge_bytes(prescale_ext, peri_wdata, peri_be);

    // Next-state for registers, prescaler, mtime and the response path
    always_comb begin
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        pcnt_d      = pcnt_q;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        shadow_hi_d = shadow_hi_q;
        rdata_d     = 32'd0;
        irq_d       = ctrl_q[1] && status;

        if (ctrl_q[0]) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        end

        // A write to either mtime half wins over a same-cycle tick
        if (wr_en && (idx == IdxMtimeLo || idx == IdxMtimeHi)) begin
            if (idx == IdxMtimeLo) mtime_d[31:0]  = merge_bytes(mtime_q[31:0], peri_wdata, peri_be);
            if (idx == IdxMtimeHi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], peri_wdata, peri_be);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_en) begin
            case (idx)
                IdxCtrl: begin
                    ctrl_d = ctrl_wr[1:0];
                    pcnt_d = '0;
                end
                IdxPrescale: begin
                    prescale_d = prescale_wr[PRESCALE_W-1:0];
                    pcnt_d     = '0;
                end
                IdxCmpLo: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], peri_wdata, peri_be);
                IdxCmpHi: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], peri_wdata, peri_be);
                default: ;
            endcase
        end

        if (rd_en) begin
            case (idx)
                IdxCtrl:     rdata_d = {30'd0, ctrl_q};
                IdxPrescale: rdata_d = prescale_ext;
                IdxMtimeLo: begin
                    rdata_d     = mtime_q[31:0];
                    shadow_hi_d = mtime_q[63:32];
                end
                IdxMtimeHi:  rdata_d = shadow_hi_q;
                IdxCmpLo:    rdata_d = mtimecmp_q[31:0];
                IdxCmpHi:    rdata_d = mtimecmp_q[63:32];
                IdxStatus:   rdata_d = {31'd0, status};
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    // State registers; reset also drops any pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= 2'd0;
            prescale_q  <= '0;
            pcnt_q      <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_hi_q <= 32'd0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            pcnt_q      <= pcnt_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            shadow_hi_q <= shadow_hi_d;
            rvalid_q    <= peri_req;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_peri_timer_slave.sv
// Directed bench for peri_timer_slave with a response scoreboard.
module tb_peri_timer_slave;

    logic        clk;
    logic        rst;
    logic        peri_req;
    logic [31:0] peri_addr;
    logic        peri_write;
    logic [3:0]  peri_be;
    logic [31:0] peri_wdata;
    logic        peri_gnt;
    logic        peri_rvalid;
    logic [31:0] peri_rdata;
    logic        irq_timer_o;

    typedef struct {
        logic [31:0] exp;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    peri_timer_slave #(.PRESCALE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .peri_req   (peri_req),
        .peri_addr  (peri_addr),
        .peri_write (peri_write),
        .peri_be    (peri_be),
        .peri_wdata (peri_wdata),
        .peri_gnt   (peri_gnt),
        .peri_rvalid(peri_rvalid),
        .peri_rdata (peri_rdata),
        .irq_timer_o(irq_timer_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && peri_rvalid) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL stray_rvalid: observed rdata %h expected no response", peri_rdata);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
                check(e.tag, peri_rdata, e.exp);
            end
        end
    end

    // Issue one request; returns 1 time unit after its grant edge
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp, input string tag);
        exp_t e;
        peri_req   = 1'b1;
        peri_write = wr;
        peri_addr  = addr;
        peri_be    = be;
        peri_wdata = wd;
        e.exp = wr ? 32'd0 : exp;
        e.due = cyc + 1;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        peri_req   = 1'b0;
        peri_write = 1'b0;
        peri_be    = 4'b0000;
        peri_wdata = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            idle(1);
            k++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        peri_req   = 1'b1;
        peri_addr  = 32'h10;
        peri_write = 1'b0;
        peri_be    = 4'b0000;
        peri_wdata = 32'd0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {31'd0, peri_gnt}, 32'd1);
        check("rst_rvalid", {31'd0, peri_rvalid}, 32'd0);
        check("rst_rdata", peri_rdata, 32'd0);
        check("rst_irq", {31'd0, irq_timer_o}, 32'd0);
        peri_req = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(1);
        issue(0, 32'h10, 4'h0, 0, 32'hFFFF_FFFF, "rst_cmp_lo");
        issue(0, 32'h14, 4'h0, 0, 32'hFFFF_FFFF, "rst_cmp_hi");
        issue(0, 32'h08, 4'h0, 0, 32'h0, "rst_mtime_lo");
        issue(0, 32'h18, 4'h0, 0, 32'h0, "rst_status");
        issue(0, 32'h00, 4'h0, 0, 32'h0, "rst_ctrl");

        // Prescale 3: one tick every 4 cycles
        issue(1, 32'h04, 4'hF, 32'd3, 0, "wr_prescale");
        issue(1, 32'h00, 4'hF, 32'd1, 0, "wr_ctrl_en");
        idle(40);
        issue(0, 32'h08, 4'h0, 0, 32'd10, "prescale_mtime_lo");
        drain("drain_prescale");

        // Carry across 32 bits and shadowed HI read
        issue(1, 32'h00, 4'hF, 32'd0, 0, "stop");
        issue(1, 32'h0C, 4'hF, 32'd0, 0, "wr_hi");
        issue(1, 32'h08, 4'hF, 32'hFFFF_FFFE, 0, "wr_lo");
        issue(1, 32'h04, 4'hF, 32'd0, 0, "wr_prescale0");
        issue(1, 32'h00, 4'hF, 32'd1, 0, "wr_en");
        issue(0, 32'h08, 4'h0, 0, 32'hFFFF_FFFE, "carry_lo");
        idle(4);
        issue(0, 32'h0C, 4'h0, 0, 32'd0, "carry_hi_shadow");
        issue(0, 32'h08, 4'h0, 0, 32'd4, "carry_lo2");
        issue(0, 32'h0C, 4'h0, 0, 32'd1, "carry_hi2");

        // Timer interrupt at mtime == 20
        issue(1, 32'h00, 4'hF, 32'd0, 0, "stop2");
        issue(1, 32'h0C, 4'hF, 32'd0, 0, "irq_hi");
        issue(1, 32'h08, 4'hF, 32'd0, 0, "irq_lo");
        issue(1, 32'h14, 4'hF, 32'd0, 0, "cmp_hi");
        issue(1, 32'h10, 4'hF, 32'd20, 0, "cmp_lo");
        issue(1, 32'h00, 4'hF, 32'd3, 0, "irq_en");
        idle(20);
        check("irq_at_20", {31'd0, irq_timer_o}, 32'd0);
        idle(1);
        check("irq_rise", {31'd0, irq_timer_o}, 32'd1);
        issue(0, 32'h18, 4'h0, 0, 32'd1, "status_set");
        issue(1, 32'h10, 4'hF, 32'hFFFF_FFFF, 0, "cmp_raise");
        check("irq_hold", {31'd0, irq_timer_o}, 32'd1);
        idle(1);
        check("irq_fall", {31'd0, irq_timer_o}, 32'd0);
        issue(0, 32'h18, 4'h0, 0, 32'd0, "status_clr");

        // Byte-lane write colliding with a tick
        issue(1, 32'h00, 4'hF, 32'd0, 0, "stop3");
        issue(1, 32'h08, 4'hF, 32'h1234_5678, 0, "be_lo_init");
        issue(1, 32'h0C, 4'hF, 32'd0, 0, "be_hi_init");
        issue(1, 32'h00, 4'hF, 32'd1, 0, "be_en");
        issue(1, 32'h08, 4'b0010, 32'h0000_AB00, 0, "be_collide");
        issue(0, 32'h08, 4'h0, 0, 32'h1234_AB78, "be_result");

        // Back-to-back mixed burst
        issue(1, 32'h00, 4'hF, 32'd0, 0, "b1_stop");
        issue(1, 32'h10, 4'hF, 32'h0000_1111, 0, "b2_cmp");
        issue(0, 32'h10, 4'h0, 0, 32'h0000_1111, "b3_cmp_rd");
        issue(0, 32'h40, 4'h0, 0, 32'd0, "b4_unmapped");
        issue(1, 32'h04, 4'hF, 32'hFFFF_FFFF, 0, "b5_prescale");
        issue(0, 32'h04, 4'h0, 0, 32'h0000_FFFF, "b6_prescale_rd");
        issue(0, 32'h06, 4'h0, 0, 32'd0, "b7_misaligned");
        issue(0, 32'h18, 4'h0, 0, 32'd1, "b8_status");

        // Dropped writes
        issue(1, 32'h1C, 4'hF, 32'hDEAD_BEEF, 0, "wr_unmapped");
        issue(1, 32'h18, 4'hF, 32'd0, 0, "wr_status");
        issue(1, 32'h10, 4'h0, 32'd0, 0, "wr_be0");
        issue(1, 32'h12, 4'hF, 32'd0, 0, "wr_misaligned");
        issue(0, 32'h10, 4'h0, 0, 32'h0000_1111, "cmp_kept");
        issue(0, 32'h18, 4'h0, 0, 32'd1, "status_kept");
        drain("drain_burst");

        // Reset while a response is pending
        issue(0, 32'h00, 4'h0, 0, 32'd0, "pre_rst_ctrl");
        peri_req   = 1'b1;
        peri_write = 1'b0;
        peri_addr  = 32'h10;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        peri_req = 1'b0;
        #1;
        check("midrst_rvalid", {31'd0, peri_rvalid}, 32'd0);
        check("midrst_rdata", peri_rdata, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(3);
        drain("drain_rst");
        issue(0, 32'h10, 4'h0, 0, 32'hFFFF_FFFF, "post_rst_cmp");
        issue(0, 32'h04, 4'h0, 0, 32'd0, "post_rst_prescale");
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
